data_memory_arbiter: RTL

//   Shares the single-port DataMemory (RW, DAddr, DataIn, DataOut) between two

---
 rtl/data_memory_arbiter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/data_memory_arbiter.sv
// Two-port arbiter in front of a single-port data memory.
// Each transaction runs IDLE -> ACCESS -> RESP, so one memory access completes every three cycles.
module data_memory_arbiter #(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int PRIORITY_MODE = 0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  Req0,
  input  logic                  RW0,
  input  logic [ADDR_WIDTH-1:0] Addr0,
  input  logic [DATA_WIDTH-1:0] WData0,
  output logic                  Ack0,
  output logic [DATA_WIDTH-1:0] RData0,
  input  logic                  Req1,
  input  logic                  RW1,
  input  logic [ADDR_WIDTH-1:0] Addr1,
  input  logic [DATA_WIDTH-1:0] WData1,
  output logic                  Ack1,
  output logic [DATA_WIDTH-1:0] RData1,
  output logic                  MemRW,
  output logic [ADDR_WIDTH-1:0] MemAddr,
  output logic [DATA_WIDTH-1:0] MemDataIn,
  input  logic [DATA_WIDTH-1:0] MemDataOut,
  output logic                  Busy,
  output logic                  GrantId
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                state_q, state_d;
  logic                  rw_q, rw_d;
  logic                  mem_rw_q, mem_rw_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_data_q, mem_data_d;
  logic                  grant_q, grant_d;
  logic                  last_grant_q, last_grant_d;
  logic                  ack0_q, ack0_d, ack1_q, ack1_d;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic                  busy_q, busy_d;
  logic                  win;

  // Port 1 wins when it is the only requester, or on a tie in round-robin mode if port 0 was served last.
  always_comb begin
    win = Req1 && (!Req0 || (PRIORITY_MODE == 0 && !last_grant_q));
  end

  always_comb begin
    state_d      = state_q;
    rw_d         = rw_q;
    mem_rw_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    busy_d       = busy_q;
    case (state_q)
      IDLE: begin
        if (Req0 || Req1) begin
          grant_d    = win;
          rw_d       = win ? RW1 : RW0;
          mem_rw_d   = win ? RW1 : RW0;
          mem_addr_d = win ? Addr1 : Addr0;
          mem_data_d = win ? WData1 : WData0;
          busy_d     = 1'b1;
          state_d    = ACCESS;
        end
      end
      ACCESS: begin
        if (!rw_q) begin
          if (grant_q) rdata1_d = MemDataOut;
          else         rdata0_d = MemDataOut;
        end
        ack0_d  = !grant_q;
        ack1_d  = grant_q;
        state_d = RESP;
      end
      RESP: begin
        last_grant_d = grant_q;
        busy_d       = 1'b0;
        state_d      = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // last_grant resets to 1 so that port 0 wins the first tie.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= IDLE;
      rw_q         <= 1'b0;
      mem_rw_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rw_q         <= rw_d;
      mem_rw_q     <= mem_rw_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
      busy_q       <= busy_d;
    end
  end

  assign MemRW     = mem_rw_q;
  assign MemAddr   = mem_addr_q;
  assign MemDataIn = mem_data_q;
  assign Ack0      = ack0_q;
  assign Ack1      = ack1_q;
  assign RData0    = rdata0_q;
  assign RData1    = rdata1_q;
  assign Busy      = busy_q;
  assign GrantId   = grant_q;

endmodule
